// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, constants and regfile state type
package cpu_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int REG_ZERO = 0;
    typedef enum logic {CLEAR, RUN} rf_state_e;
endpackage

// File: rtl/regfile_wb_if.sv
// regfile_wb_if: write-back triple, two read ports and ready flag
interface regfile_wb_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              ready;
    modport master (output we, waddr, wdata, re1, raddr1, re2, raddr2, input rdata1, rdata2, ready);
    modport slave  (input we, waddr, wdata, re1, raddr1, re2, raddr2, output rdata1, rdata2, ready);
endinterface

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset sweep that zeroes every entry, then raises ready
module regfile_clear_seq #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_idx_o,
    output logic              ready_o
);
    import cpu_pkg::*;
    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              last;
    // advance the sweep pointer; the edge clearing the top index ends the sweep
    always_comb begin
        last    = (state_q == CLEAR) && (&ptr_q);
        state_d = last ? RUN : state_q;
        ptr_d   = (state_q == CLEAR) ? ptr_q + 1'b1 : ptr_q;
        ready_d = ready_q | last;
    end
    // sequencer state, restarted from index 0 by every reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end
    assign clr_we_o  = (state_q == CLEAR);
    assign clr_idx_o = ptr_q;
    assign ready_o   = ready_q;
endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: write-back register file with bypassed read ports and zero r0
module regfile_wb #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input logic         clk,
    input logic         rst_n,
    regfile_wb_if.slave bus
);
    import cpu_pkg::*;
    localparam int NREG = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem_q [NREG];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;

    regfile_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we_o  (clr_we),
        .clr_idx_o (clr_idx),
        .ready_o   (ready)
    );

    // the clear sweep owns the write port until it finishes; external writes are dropped
    always_comb begin
        wr_en   = clr_we | (bus.we && bus.waddr != ADDR_W'(REG_ZERO));
        wr_idx  = clr_we ? clr_idx : bus.waddr;
        wr_data = clr_we ? '0 : bus.wdata;
    end

    // storage without a parallel reset; nothing is written on a reset edge
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem_q[wr_idx] <= wr_data;
    end

    function automatic logic [DATA_W-1:0] rd_port(
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic [DATA_W-1:0] stored
    );
        return (!re || raddr == ADDR_W'(REG_ZERO) || !ready) ? '0 :
               (bus.we && bus.waddr == raddr) ? bus.wdata : stored;
    endfunction

    assign bus.rdata1 = rd_port(bus.re1, bus.raddr1, mem_q[bus.raddr1]);
    assign bus.rdata2 = rd_port(bus.re2, bus.raddr2, mem_q[bus.raddr2]);
    assign bus.ready  = ready;
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: randomized and directed checks against a behavioural regfile model
module tb_regfile_wb;
    localparam int NREG = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vecs = 0;
    int errs = 0;
    logic [31:0] m_mem [NREG];
    bit m_ready = 1'b0;
    int m_cnt = 0;

    regfile_wb_if #(.ADDR_W(5), .DATA_W(32)) bus ();
    regfile_wb #(.ADDR_W(5), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (!re || a == 0 || !m_ready) return 32'h0;
        if (bus.we && bus.waddr == a) return bus.wdata;
        return m_mem[a];
    endfunction

    task automatic step();
        if (!rst_n) begin
            m_cnt = 0;
            m_ready = 1'b0;
            foreach (m_mem[i]) m_mem[i] = 32'h0;
        end else if (!m_ready) begin
            m_cnt++;
            m_ready = (m_cnt == NREG);
        end else if (bus.we && bus.waddr != 0) begin
            m_mem[bus.waddr] = bus.wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 0; bus.waddr = 0; bus.wdata = 0;
        bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (3) step();
        bus.re1 = 1; bus.raddr1 = 5;
        #1;
        vecs++;
        if (bus.ready !== 1'b0 || bus.rdata1 !== 32'h0) begin
            errs++;
            $display("FAIL reset_hold ready=%b rdata1=%h want ready=0 rdata1=0", bus.ready, bus.rdata1);
        end
        rst_n = 1;
        for (int i = 1; i <= NREG; i++) begin
            step();
            vecs++;
            if (bus.ready !== (i == NREG)) begin
                errs++;
                $display("FAIL reset_latency edge %0d ready=%b want %b", i, bus.ready, i == NREG);
            end
        end
        for (int a = 0; a < NREG; a++) begin
            bus.re1 = 1; bus.raddr1 = 5'(a); bus.re2 = 1; bus.raddr2 = 5'(NREG - 1 - a);
            #1;
            vecs++;
            if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
                errs++;
                $display("FAIL reset_clear idx %0d rdata1=%h rdata2=%h want 0", a, bus.rdata1, bus.rdata2);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        bus.we = 1; bus.waddr = 5; bus.wdata = 32'hDEADBEEF;
        step();
        idle();
        bus.re1 = 1; bus.raddr1 = 5;
        #1;
        vecs++;
        if (bus.rdata1 !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL write_read rdata1=%h want deadbeef", bus.rdata1);
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.we = 1; bus.waddr = 7; bus.wdata = 32'h12345678;
        bus.re1 = 1; bus.raddr1 = 7; bus.re2 = 1; bus.raddr2 = 7;
        #1;
        vecs++;
        if (bus.rdata1 !== 32'h12345678 || bus.rdata2 !== 32'h12345678) begin
            errs++;
            $display("FAIL bypass rdata1=%h rdata2=%h want 12345678", bus.rdata1, bus.rdata2);
        end
        step();
        bus.we = 0;
        #1;
        vecs++;
        if (bus.rdata1 !== 32'h12345678 || bus.rdata2 !== 32'h12345678) begin
            errs++;
            $display("FAIL bypass_stored rdata1=%h rdata2=%h want 12345678", bus.rdata1, bus.rdata2);
        end
    endtask

    task automatic test_r0_enables();
        idle();
        bus.we = 1; bus.waddr = 0; bus.wdata = 32'hFFFFFFFF;
        bus.re1 = 1; bus.raddr1 = 0; bus.re2 = 1; bus.raddr2 = 0;
        #1;
        vecs++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            errs++;
            $display("FAIL r0_bypass rdata1=%h rdata2=%h want 0", bus.rdata1, bus.rdata2);
        end
        step();
        bus.we = 0;
        #1;
        vecs++;
        if (bus.rdata1 !== 32'h0) begin
            errs++;
            $display("FAIL r0_read rdata1=%h want 0", bus.rdata1);
        end
        bus.we = 1; bus.waddr = 9; bus.wdata = 32'h55;
        bus.re2 = 0; bus.raddr2 = 9;
        #1;
        vecs++;
        if (bus.rdata2 !== 32'h0) begin
            errs++;
            $display("FAIL re2_off_bypass rdata2=%h want 0", bus.rdata2);
        end
        step();
        bus.we = 0;
        #1;
        vecs++;
        if (bus.rdata2 !== 32'h0) begin
            errs++;
            $display("FAIL re2_off rdata2=%h want 0", bus.rdata2);
        end
        bus.re2 = 1;
        #1;
        vecs++;
        if (bus.rdata2 !== 32'h55) begin
            errs++;
            $display("FAIL re2_on rdata2=%h want 55", bus.rdata2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.we = 1'($urandom); bus.waddr = 5'($urandom); bus.wdata = $urandom;
            bus.re1 = ($urandom_range(3) != 0); bus.raddr1 = ($urandom_range(3) == 0) ? bus.waddr : 5'($urandom);
            bus.re2 = ($urandom_range(3) != 0); bus.raddr2 = ($urandom_range(3) == 0) ? bus.raddr1 : 5'($urandom);
            #1;
            vecs++;
            if (bus.rdata1 !== exp_rd(bus.re1, bus.raddr1) || bus.rdata2 !== exp_rd(bus.re2, bus.raddr2)) begin
                errs++;
                $display("FAIL random #%0d rdata1=%h/%h rdata2=%h/%h (got/want)", n,
                         bus.rdata1, exp_rd(bus.re1, bus.raddr1), bus.rdata2, exp_rd(bus.re2, bus.raddr2));
            end
            step();
        end
        idle();
    endtask

    task automatic test_write_during_clear();
        idle();
        bus.we = 1; bus.waddr = 3; bus.wdata = 32'h99;
        step();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 1; i <= NREG; i++) begin
            bus.we = (i == 10); bus.waddr = 3; bus.wdata = 32'hAA;
            step();
            vecs++;
            if (bus.ready !== m_ready) begin
                errs++;
                $display("FAIL clear_write_ready edge %0d ready=%b want %b", i, bus.ready, m_ready);
            end
        end
        idle();
        bus.re1 = 1; bus.raddr1 = 3;
        #1;
        vecs++;
        if (bus.rdata1 !== 32'h0) begin
            errs++;
            $display("FAIL clear_write_dropped r3=%h want 0", bus.rdata1);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        bus.we = 1; bus.waddr = 3; bus.wdata = 32'h77;
        step();
        idle();
        rst_n = 0;
        step();
        vecs++;
        if (bus.ready !== 1'b0) begin
            errs++;
            $display("FAIL mid_run_reset ready=%b want 0", bus.ready);
        end
        rst_n = 1;
        repeat (15) step();
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 1; i <= NREG; i++) begin
            step();
            vecs++;
            if (bus.ready !== (i == NREG)) begin
                errs++;
                $display("FAIL mid_clear_latency edge %0d ready=%b want %b", i, bus.ready, i == NREG);
            end
        end
        bus.re1 = 1; bus.raddr1 = 3; bus.re2 = 1; bus.raddr2 = 5;
        #1;
        vecs++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            errs++;
            $display("FAIL mid_reset_cleared r3=%h r5=%h want 0", bus.rdata1, bus.rdata2);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_r0_enables();
        test_random();
        test_write_during_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/regfile_wb.md
# regfile_wb

Architectural register file at the far end of the write-back path: consumes the `we`/`waddr`/`wdata` triple delivered by the memory stage and serves two combinational read ports to the decode stage. Same-cycle write-to-read bypass is built in, and `r0` is hard-wired to zero. After every reset, an internal clear sequencer sweeps the storage to zero and holds `ready` low until the sweep is done, so the array can map to flop or RAM storage without a wide parallel reset.

## Interface
- `ADDR_W`, default 5: register index width; `NREG = 2**ADDR_W` entries.
- `DATA_W`, default 32: register width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `we`  in  1  write enable from the write-back path.
- `waddr`  in  ADDR_W  write index.
- `wdata`  in  DATA_W  write data.
- `re1`  in  1  read-port-1 enable.
- `raddr1`  in  ADDR_W  read-port-1 index.
- `rdata1`  out  DATA_W  read-port-1 data, combinational.
- `re2`  in  1  read-port-2 enable.
- `raddr2`  in  ADDR_W  read-port-2 index.
- `rdata2`  out  DATA_W  read-port-2 data, combinational.
- `ready`  out  1  registered; high once the clear sweep is complete.

## Operation
- States: `CLEAR`, `RUN`. A clear pointer `ptr` is ADDR_W bits wide.
- `rst_n` low at an edge:
  - `state <= CLEAR`, `ptr <= 0`, `ready <= 0`.
  - No array write occurs on that edge.
- `CLEAR` (edge with `rst_n` high):
  - `mem[ptr] <= 0`, then `ptr <= ptr + 1`.
  - On the edge that writes `ptr == NREG-1`: `state <= RUN`, `ready <= 1`.
  - `ptr` wraps to 0 on that edge, and its value is don't-care in `RUN`.
- External writes during `CLEAR` are dropped. No queuing, no error flag.
- `RUN`:
  - On an edge with `we=1` and `waddr != 0`: `mem[waddr] <= wdata`.
  - Writes to index 0 are discarded.
- Read port `k` (k = 1, 2):
  - `rdatak = 0` if `rek == 0`, or `raddrk == 0`, or `ready == 0`.
  - Else `rdatak = wdata` if `we == 1` and `waddr == raddrk` (bypass).
  - Else `rdatak = mem[raddrk]`.
- Both ports may read the same index, and both may bypass in the same cycle.
- Reset mid-`CLEAR` or mid-`RUN`: the sweep restarts from 0. Prior contents are not guaranteed until `ready` rises again.

## Timing
- Reset values: `ready = 0`, `state = CLEAR`, `ptr = 0`. `rdata1` and `rdata2` are 0 (forced by `ready = 0`).
- Clear latency: `ready` rises on exactly the NREG-th edge after the last edge at which `rst_n` was sampled low. That is 32 edges at default parameters.
- Write-to-array latency is 1 edge. The bypass gives the same cycle's reader zero effective latency.
- The read path is purely combinational from `re*`, `raddr*`, `we`, `waddr`, `wdata`, `ready` and `mem`. There is no registered read.
- Upstream must hold the pipeline, or accept dropped write-backs, while `ready = 0`.

## Structure
- Shared package `cpu_pkg`:
  - Widths: `ADDR_W`, `DATA_W`.
  - Constant `REG_ZERO = 0`.
  - Regfile state enum `{CLEAR, RUN}`.
- Sub-module `regfile_clear_seq` owns `state`, `ptr` and `ready`. It outputs a clear write-enable and a clear index.
- The top level muxes two write sources into the array:
  - the clear write (value 0, index `ptr`) while `state == CLEAR`;
  - the external write otherwise.
- The top level also holds the two read/bypass muxes, implemented as one function or generate instance per port.

## Test plan
- Reset release:
  - Stimulus: hold `rst_n` low for 3 edges, then release.
  - Required: `ready` is 0 for edges 1–31 and 1 exactly at edge 32; `rdata1` and `rdata2` read 0 for all indices after `ready` rises.
- Write then read:
  - Stimulus: in `RUN`, write `r5 = 0xDEADBEEF`; next cycle `re1 = 1`, `raddr1 = 5`.
  - Required: `rdata1 = 0xDEADBEEF`.
- Bypass:
  - Stimulus: `we = 1`, `waddr = 7`, `wdata = 0x12345678`; in the same cycle `raddr1 = raddr2 = 7`, `re1 = re2 = 1`.
  - Required: both ports return `0x12345678` combinationally; `mem[7]` holds the value after the edge.
- `r0` and enables:
  - Stimulus: write `0xFFFFFFFF` to index 0, then read index 0. Separately, write `r9 = 0x55` and read it with `re2 = 0`.
  - Required: index 0 reads 0 (including during the bypass cycle); `rdata2 = 0` while `re2 = 0`.
- Write during `CLEAR`:
  - Stimulus: drive `we = 1`, `waddr = 3`, `wdata = 0xAA` on edge 10 after reset release.
  - Required: after `ready` rises, `r3` reads 0.
- Reset mid-operation:
  - Stimulus: write `r3 = 0x77`, then drive `rst_n` low for 1 edge.
  - Required: `ready` is 0 on the next cycle and rises 32 edges after release; `r3` then reads 0. Repeat with the reset asserted mid-`CLEAR` and check that the full 32-edge latency applies.
